uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between N_REQ byte-level requesters using a round-robin policy.
- For each granted requester it latches the byte, drives the transmitter start strobe and data, and waits for the transmitter's completion flag.
- It then returns a per-requester done or error pulse.
- Sits between client logic and the UART top level, in the system clock domain.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- STR_HOLD, 16, system-clock cycles tx_str is held high; must be at least one transmitter bit-clock period.
- TIMEOUT, 65535, system-clock cycles to wait for completion before aborting (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester request level.
- req_data  in  8*N_REQ  byte for requester i in bits [8i+7:8i].
- grant  out  N_REQ  one-hot, high from acceptance until the response pulse.
- done  out  N_REQ  one-cycle pulse, byte sent without error.
- err  out  N_REQ  one-cycle pulse, transmitter error or timeout.
- busy  out  1  high whenever state is not IDLE.
- tx_str  out  1  start strobe to the UART transmitter.
- tx_data  out  8  byte to the UART transmitter.
- tx_done  in  1  transmitter done flag, asynchronous to clk.
- tx_er  in  1  transmitter error flag, asynchronous to clk.

Behaviour:
Reset (rst low, asynchronous):
- grant, done, err, busy, tx_str = 0; tx_data = 0.
- State = IDLE; round-robin pointer = 0; synchronizers cleared.
- Asserting reset mid-transfer aborts immediately; no response pulse is produced.

Synchronizers:
- tx_done and tx_er each pass through a 2-FF synchronizer.
- done_rise = synced tx_done high AND previous synced value low.
- The synced tx_er is sampled on the done_rise cycle.

State machine IDLE -> START -> WAIT -> RESP -> IDLE:
- IDLE:
  - If any req bit is high, select the first set bit searching from the pointer upward with wrap (pointer itself checked first).
  - Next cycle: grant[sel] = 1, tx_data = the latched byte, tx_str = 1, load hold counter = STR_HOLD-1, enter START.
  - Latency from req rising to grant/tx_str rising is 1 cycle.
- START:
  - tx_str held high; counter decrements each cycle.
  - At 0: tx_str = 0, enter WAIT.
  - tx_str is therefore high for exactly STR_HOLD cycles.
- WAIT:
  - On done_rise, record status = synced tx_er and enter RESP.
  - A done_rise already occurring during START is ignored; the hold window must elapse first.
- RESP (one cycle):
  - If status = 0, done[sel] = 1; otherwise err[sel] = 1.
  - grant drops to 0 at the same edge.
  - pointer = sel+1, wrapping to 0 after N_REQ-1.
  - Return to IDLE.

Handshake and arbitration rules:
- tx_data is stable from grant until RESP; it comes from the latched byte, so changes on req_data after acceptance have no effect.
- req dropping after acceptance does not cancel the transfer; the response is still pulsed.
- A requester keeping req high gets its next grant no earlier than 1 cycle after its response (IDLE re-arbitrates).
- Fairness: with all req bits high, grants rotate 0,1,...,N_REQ-1,0.
- Simultaneous new requests in IDLE are resolved purely by round-robin order.
- Minimum per-byte overhead: 1 (IDLE) + STR_HOLD + 2 (sync) + 1 (RESP) cycles, plus the UART frame time.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - A 32-bit watchdog counter is cleared on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT before done_rise, status is forced to 1 and the block enters RESP, giving an err pulse.
  - Pointer advance is the same as a normal completion.
- Not defined:
  - No counter is instantiated; WAIT waits indefinitely for done_rise.
  - The TIMEOUT parameter is ignored.

Test Plan:
- Reset and single request: reset held low, then released; req=4'b0001, data 0xA5.
  - Expect grant=0001 and tx_str high 1 cycle after req, for exactly 16 cycles, with tx_data=0xA5.
  - Model raises tx_done. Expect done[0] pulse 3 cycles later, then busy=0.
- Round robin: req=4'b1111 with bytes 0x11/0x22/0x33/0x44, done model always responds.
  - Expect grant order 0,1,2,3,0 and tx_data sequence 0x11,0x22,0x33,0x44,0x11.
- Error path: req[2]=1; model raises tx_done together with tx_er=1.
  - Expect err[2] one-cycle pulse, done[2] stays 0, and the next grant goes to requester 3 if requesting.
- Data stability: req[1]=1 with 0x5A; change req_data[15:8] to 0xFF and drop req[1] during WAIT.
  - Expect tx_data to stay 0x5A and a done[1] pulse to still occur.
- Reset mid-transfer: assert rst low during START.
  - Expect tx_str, grant and busy at 0 immediately (asynchronously), no done/err pulse, and pointer 0 after release.
- Timeout (UART_ARB_TIMEOUT_EN defined, TIMEOUT=100): req[3]=1 and the model never raises tx_done.
  - Expect err[3] pulse 100 cycles after entering WAIT, then IDLE.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among N_REQ byte requesters.
// Define UART_ARB_TIMEOUT_EN to abort a transfer with an err pulse after TIMEOUT cycles in WAIT.
module uart_tx_arbiter #(
    parameter int N_REQ    = 4,
    parameter int STR_HOLD = 16,
    parameter int TIMEOUT  = 65535
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [8*N_REQ-1:0] i_req_data,
    output logic [N_REQ-1:0]   o_grant,
    output logic [N_REQ-1:0]   o_done,
    output logic [N_REQ-1:0]   o_err,
    output logic               o_busy,
    output logic               o_tx_str,
    output logic [7:0]         o_tx_data,
    input  logic               i_tx_done,
    input  logic               i_tx_er
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(STR_HOLD + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t             r_state;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_sel;
    logic [CW-1:0]      r_cnt;
    logic [N_REQ-1:0]   r_grant;
    logic [N_REQ-1:0]   r_done;
    logic [N_REQ-1:0]   r_err;
    logic               r_busy;
    logic               r_tx_str;
    logic [7:0]         r_tx_data;
    logic [2:0]         r_dn_s;
    logic [1:0]         r_er_s;
    logic [PW-1:0]      w_sel;
    logic [7:0]         w_byte;
    logic               w_done_rise;
`ifdef UART_ARB_TIMEOUT_EN
    logic [31:0]        r_wd;
`else
    logic               w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
`endif

    assign o_grant     = r_grant;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_busy      = r_busy;
    assign o_tx_str    = r_tx_str;
    assign o_tx_data   = r_tx_data;
    assign w_done_rise = r_dn_s[1] & ~r_dn_s[2];

    // Walk downward so the candidate closest to the pointer is the last one written.
    always_comb begin
        logic [PW-1:0] v_idx;
        v_idx  = '0;
        w_sel  = r_ptr;
        w_byte = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            v_idx = PW'((int'(r_ptr) + k) % N_REQ);
            if (i_req[v_idx]) w_sel = v_idx;
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (w_sel == PW'(k)) w_byte = i_req_data[8*k +: 8];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dn_s <= '0;
            r_er_s <= '0;
        end else begin
            r_dn_s <= {r_dn_s[1:0], i_tx_done};
            r_er_s <= {r_er_s[0], i_tx_er};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_sel     <= '0;
            r_cnt     <= '0;
            r_grant   <= '0;
            r_done    <= '0;
            r_err     <= '0;
            r_busy    <= 1'b0;
            r_tx_str  <= 1'b0;
            r_tx_data <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            r_wd      <= '0;
`endif
        end else begin
            r_done <= '0;
            r_err  <= '0;
            case (r_state)
                IDLE: begin
                    if (|i_req) begin
                        r_sel     <= w_sel;
                        r_grant   <= N_REQ'(1) << w_sel;
                        r_tx_data <= w_byte;
                        r_tx_str  <= 1'b1;
                        r_cnt     <= CW'(STR_HOLD - 1);
                        r_busy    <= 1'b1;
                        r_state   <= START;
                    end
                end
                START: begin
                    if (r_cnt == '0) begin
                        r_tx_str <= 1'b0;
                        r_state  <= WAIT;
`ifdef UART_ARB_TIMEOUT_EN
                        r_wd     <= '0;
`endif
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                WAIT: begin
                    if (w_done_rise) begin
                        r_done  <= r_er_s[1] ? '0 : r_grant;
                        r_err   <= r_er_s[1] ? r_grant : '0;
                        r_grant <= '0;
                        r_state <= RESP;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (r_wd == 32'(TIMEOUT - 1)) begin
                        r_err   <= r_grant;
                        r_grant <= '0;
                        r_state <= RESP;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
`endif
                end
                default: begin
                    r_ptr   <= (r_sel == PW'(N_REQ - 1)) ? '0 : r_sel + 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized bench for uart_tx_arbiter against a transaction-level model.
// Define UART_ARB_TIMEOUT_EN to also exercise the watchdog abort path.
module tb_uart_tx_arbiter;
    localparam int N_REQ    = 4;
    localparam int STR_HOLD = 16;
    localparam int TIMEOUT  = 100;
`ifdef UART_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic        tx_done = 1'b0;
    logic        tx_er = 1'b0;
    logic [3:0]  grant, done, err;
    logic        busy, tx_str;
    logic [7:0]  tx_data;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N_REQ), .STR_HOLD(STR_HOLD), .TIMEOUT(TIMEOUT)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_req_data(req_data),
        .o_grant(grant), .o_done(done), .o_err(err), .o_busy(busy),
        .o_tx_str(tx_str), .o_tx_data(tx_data), .i_tx_done(tx_done), .i_tx_er(tx_er)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit m_active = 1'b0;
    bit m_er = 1'b0;
    int m_g = 0, m_sel = 0, m_resp = -1, m_free = 0, m_ptr = 0, m_dly = 0;
    logic [7:0] m_byte = '0;
    bit no_tx = 1'b0;
    bit early = 1'b0;
    int er_mode = 0;
    int glog[$];
    int dlog[$];
    logic [3:0] last_g = '0;
    int str_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input int ptr, input logic [3:0] r);
        for (int k = 0; k < N_REQ; k++)
            if (r[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
        return -1;
    endfunction

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_ptr    = 0;
        m_free   = 0;
        m_resp   = -1;
        tx_done  = 1'b0;
        tx_er    = 1'b0;
    endtask

    task automatic step();
        logic [3:0]  p_req, e_grant, e_done, e_err;
        logic [31:0] p_data;
        logic        p_rst, e_str;
        p_req  = req;
        p_data = req_data;
        p_rst  = rst_n;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_n) begin
            if (m_active && m_resp >= 0 && cyc == m_resp + 1) begin
                m_active = 1'b0;
                m_free   = cyc + 1;
            end
            if (!m_active && p_rst && cyc >= m_free && p_req != 0) begin
                m_sel    = rr_pick(m_ptr, p_req);
                m_byte   = p_data[8*m_sel +: 8];
                m_g      = cyc;
                m_resp   = -1;
                m_active = 1'b1;
                m_dly    = $urandom_range(0, 4);
                m_er     = (er_mode == 2) ? ($urandom_range(0, 3) == 0) : (er_mode == 1);
            end
            // Transmitter model: completion some cycles after the strobe window ends.
            if (m_active && m_resp < 0) begin
                if (early && cyc == m_g + 3) tx_done = 1'b1;
                if (early && cyc == m_g + 8) tx_done = 1'b0;
                if (!no_tx && cyc == m_g + STR_HOLD + m_dly) begin
                    tx_done = 1'b1;
                    tx_er   = m_er;
                    m_resp  = cyc + 3;
                end
                if (no_tx && TO_EN && cyc == m_g + STR_HOLD) begin
                    m_er   = 1'b1;
                    m_resp = m_g + STR_HOLD + TIMEOUT;
                end
            end
        end
        e_grant = (m_active && (m_resp < 0 || cyc < m_resp)) ? 4'(1 << m_sel) : 4'h0;
        e_str   = m_active && (cyc <= m_g + STR_HOLD - 1);
        e_done  = (m_active && cyc == m_resp && !m_er) ? 4'(1 << m_sel) : 4'h0;
        e_err   = (m_active && cyc == m_resp && m_er) ? 4'(1 << m_sel) : 4'h0;
        chk("grant", grant, e_grant);
        chk("tx_str", tx_str, e_str);
        chk("busy", busy, m_active);
        chk("done", done, e_done);
        chk("err", err, e_err);
        if (m_active) chk("tx_data", tx_data, m_byte);
        if (!rst_n) chk("rst_tx_data", tx_data, 8'h00);
        if (m_active && cyc == m_resp) begin
            tx_done = 1'b0;
            tx_er   = 1'b0;
            m_ptr   = (m_sel + 1) % N_REQ;
        end
        if (grant != 0 && last_g == 0) begin
            for (int k = 0; k < N_REQ; k++) if (grant[k]) glog.push_back(k);
            dlog.push_back(int'(tx_data));
        end
        last_g = grant;
        if (tx_str) str_cnt++;
    endtask

    task automatic do_reset(input int hold);
        rst_n = 1'b0;
        #1;
        chk("async_rst_grant", grant, 4'h0);
        chk("async_rst_str", tx_str, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_resp", {done, err}, 8'h00);
        model_reset();
        repeat (hold) step();
        rst_n = 1'b1;
    endtask

    initial begin
        int rr_exp[5];
        int rd_exp[5];
        rr_exp = '{0, 1, 2, 3, 0};
        rd_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;

        // Single request
        req = 4'b0001;
        req_data = 32'h0000_00A5;
        glog.delete(); dlog.delete(); str_cnt = 0;
        step();
        req = '0;
        repeat (35) step();
        chk("p1_str_len", str_cnt, STR_HOLD);
        chk("p1_grant", qget(glog, 0), 0);
        chk("p1_data", qget(dlog, 0), 8'hA5);

        // Round robin with all requesters active
        do_reset(2);
        glog.delete(); dlog.delete();
        req = 4'b1111;
        req_data = 32'h4433_2211;
        repeat (110) step();
        req = '0;
        repeat (30) step();
        for (int i = 0; i < 5; i++) begin
            chk("rr_order", qget(glog, i), rr_exp[i]);
            chk("rr_data", qget(dlog, i), rd_exp[i]);
        end

        // Error path then the next requester in order
        do_reset(2);
        glog.delete();
        er_mode = 1;
        req = 4'b1100;
        req_data = 32'hC3B2_0000;
        step();
        er_mode = 0;
        repeat (45) step();
        req = '0;
        repeat (30) step();
        chk("err_first", qget(glog, 0), 2);
        chk("err_next", qget(glog, 1), 3);

        // Latched data, req withdrawn in WAIT, spurious completion during the strobe window
        early = 1'b1;
        req = 4'b0010;
        req_data = 32'h0000_5A00;
        step();
        repeat (17) step();
        req_data[15:8] = 8'hFF;
        req = '0;
        repeat (30) step();
        early = 1'b0;

        // Random traffic
        er_mode = 2;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            req_data = $urandom;
            step();
        end
        req = '0;
        er_mode = 0;
        repeat (40) step();

        // Reset in the middle of START, pointer restarts at 0
        req = 4'b0100;
        step();
        req = '0;
        repeat (4) step();
        do_reset(3);
        glog.delete();
        req = 4'b1111;
        step();
        req = '0;
        repeat (40) step();
        chk("rst_ptr", qget(glog, 0), 0);

`ifdef UART_ARB_TIMEOUT_EN
        no_tx = 1'b1;
        req = 4'b1000;
        step();
        req = '0;
        repeat (STR_HOLD + TIMEOUT + 20) step();
        no_tx = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
